// File: rtl/loader_pkg.sv
// Shared constants for the boot-time memory loaders: FSM state encodings and
// the status bytes returned to the host once a load has finished.
package loader_pkg;

    localparam logic [1:0] LEN  = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_OVF = 8'hEE;

    function automatic logic [7:0] ack_code(input logic ovf);
        return ovf ? ACK_OVF : ACK_OK;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into big-endian 32-bit words; word_valid pulses in the
// cycle the fourth byte arrives, with that byte already merged into word.
module word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift <= '0;
            count <= '0;
        end else if (clear) begin
            shift <= '0;
            count <= '0;
        end else if (byte_valid) begin
            shift <= {shift[15:0], byte_data};
            count <= count + 2'd1;
        end
    end

    assign word       = {shift, byte_data};
    assign word_valid = byte_valid && (count == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes the words into
// instruction memory from address 0, then reports status and holds in DONE.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int NUM_WORDS = 1024,
    localparam int AW = $clog2(NUM_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          done,
    output logic          overflow
);

    logic [1:0]  state;
    logic [31:0] count;
    logic [31:0] index;
    logic [31:0] word;
    logic        word_valid;
    logic        accept;
    logic        rearm;
    logic        in_range;
    logic        last_word;

    // NOTE: rx_ready is gated by reset directly so it reads 0 while reset is held.
    assign rx_ready  = !reset && (state == LEN || state == DATA);
    assign accept    = rx_valid && rx_ready;
    assign rearm     = (state == DONE) && start;
    assign in_range  = index < 32'(NUM_WORDS);
    assign last_word = (index + 32'd1) == count;

    word_assembler u_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (rearm),
        .byte_valid (accept),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LEN;
            count      <= '0;
            index      <= '0;
            overflow   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN: begin
                    if (word_valid) begin
                        count <= word;
                        index <= '0;
                        if (word == 32'd0) begin
                            state    <= ACK;
                            tx_valid <= 1'b1;
                            tx_data  <= ack_code(overflow);
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        if (in_range) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= index[AW-1:0];
                            imem_wdata <= word;
                        end else begin
                            overflow <= 1'b1;
                        end
                        index <= index + 32'd1;
                        // The status byte must already reflect an overflow on this final word.
                        if (last_word) begin
                            state    <= ACK;
                            tx_valid <= 1'b1;
                            tx_data  <= ack_code(overflow || !in_range);
                        end
                    end
                end
                ACK: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state    <= LEN;
                        count    <= '0;
                        index    <= '0;
                        overflow <= 1'b0;
                        done     <= 1'b0;
                    end
                end
                default: state <= LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench: stimulus queues expected memory writes and status bytes,
// a negedge monitor pops and compares them as the loaders present outputs.
module tb_instruction_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic        sel = 1'b0;

    logic        rx_ready_a, tx_valid_a, imem_we_a, done_a, overflow_a;
    logic [7:0]  tx_data_a;
    logic [9:0]  imem_waddr_a;
    logic [31:0] imem_wdata_a;

    logic        rx_ready_b, tx_valid_b, imem_we_b, done_b, overflow_b;
    logic [7:0]  tx_data_b;
    logic [1:0]  imem_waddr_b;
    logic [31:0] imem_wdata_b;

    logic        rx_ready_m, tx_valid_m, imem_we_m, done_m, overflow_m;
    logic [7:0]  tx_data_m;
    logic [9:0]  imem_waddr_m;
    logic [31:0] imem_wdata_m;

    int errors = 0;
    int checks = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    always #5 clock = ~clock;

    instruction_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start && !sel),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid && !sel),
        .rx_ready   (rx_ready_a),
        .tx_data    (tx_data_a),
        .tx_valid   (tx_valid_a),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we_a),
        .imem_waddr (imem_waddr_a),
        .imem_wdata (imem_wdata_a),
        .done       (done_a),
        .overflow   (overflow_a)
    );

    instruction_loader #(.NUM_WORDS(4)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .start      (start && sel),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid && sel),
        .rx_ready   (rx_ready_b),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we_b),
        .imem_waddr (imem_waddr_b),
        .imem_wdata (imem_wdata_b),
        .done       (done_b),
        .overflow   (overflow_b)
    );

    assign rx_ready_m   = sel ? rx_ready_b : rx_ready_a;
    assign tx_valid_m   = sel ? tx_valid_b : tx_valid_a;
    assign tx_data_m    = sel ? tx_data_b : tx_data_a;
    assign imem_we_m    = sel ? imem_we_b : imem_we_a;
    assign imem_waddr_m = sel ? {8'b0, imem_waddr_b} : imem_waddr_a;
    assign imem_wdata_m = sel ? imem_wdata_b : imem_wdata_a;
    assign done_m       = sel ? done_b : done_a;
    assign overflow_m   = sel ? overflow_b : overflow_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_write(input logic [9:0] a, input logic [31:0] d, input bit last);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = last;
        exp_wr.push_back(e);
    endtask

    // Monitor: compares every write strobe and every status-byte cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (imem_we_m) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", {22'b0, imem_waddr_m}, 32'hFFFFFFFF);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("write_addr", {22'b0, imem_waddr_m}, {22'b0, e.addr});
                        check("write_data", imem_wdata_m, e.data);
                        if (e.last) check("last_write_with_tx_valid", {31'b0, tx_valid_m}, 32'd1);
                    end
                end
                if (tx_valid_m) begin
                    if (exp_tx.size() == 0) begin
                        check("unexpected_tx", {24'b0, tx_data_m}, 32'hFFFFFFFF);
                    end else begin
                        check("tx_data", {24'b0, tx_data_m}, {24'b0, exp_tx[0]});
                        if (tx_ready) void'(exp_tx.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clock);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!rx_ready_m && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", {31'b0, rx_ready_m}, 32'd1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[31:24], rnd ? int'($urandom_range(0, 5)) : 0);
            v = v << 8;
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clock);
        while (!done_m && t < 300) begin
            @(negedge clock);
            t++;
        end
        check(name, {31'b0, done_m}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("done_drops_after_start", {31'b0, done_m}, 32'd0);
        check("overflow_cleared", {31'b0, overflow_m}, 32'd0);
        check("rx_ready_after_start", {31'b0, rx_ready_m}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'b0, rx_ready_m}, 32'd0);
        check({tag, "_tx_valid"}, {31'b0, tx_valid_m}, 32'd0);
        check({tag, "_tx_data"}, {24'b0, tx_data_m}, 32'd0);
        check({tag, "_imem_we"}, {31'b0, imem_we_m}, 32'd0);
        check({tag, "_imem_waddr"}, {22'b0, imem_waddr_m}, 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata_m, 32'd0);
        check({tag, "_done"}, {31'b0, done_m}, 32'd0);
        check({tag, "_overflow"}, {31'b0, overflow_m}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rx_ready_after_release", {31'b0, rx_ready_m}, 32'd1);
        @(posedge clock);
        #1;

        // Two words back-to-back, transmitter always ready
        tx_ready = 1'b1;
        expect_write(10'd0, 32'h12345678, 1'b0);
        expect_write(10'd1, 32'h9ABCDEF0, 1'b1);
        exp_tx.push_back(8'hAA);
        send_word(32'h00000002, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        wait_done("done_two_words");
        check("overflow_two_words", {31'b0, overflow_m}, 32'd0);

        // Empty program
        pulse_start();
        exp_tx.push_back(8'hAA);
        send_word(32'h00000000, 1'b0);
        wait_done("done_empty");

        // Gapped stream with a stalled transmitter
        pulse_start();
        tx_ready = 1'b0;
        expect_write(10'd0, 32'h12345678, 1'b0);
        expect_write(10'd1, 32'h9ABCDEF0, 1'b1);
        exp_tx.push_back(8'hAA);
        send_word(32'h00000002, 1'b1);
        send_word(32'h12345678, 1'b1);
        send_word(32'h9ABCDEF0, 1'b1);
        repeat (10) @(posedge clock);
        #1;
        check("tx_valid_held", {31'b0, tx_valid_m}, 32'd1);
        check("done_low_while_stalled", {31'b0, done_m}, 32'd0);
        tx_ready = 1'b1;
        wait_done("done_gapped");

        // Reset in the middle of the second word
        pulse_start();
        expect_write(10'd0, 32'h11223344, 1'b0);
        send_word(32'h00000002, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1'b1;
        #1;
        check_reset_values("midload");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        expect_write(10'd0, 32'hDEADBEEF, 1'b1);
        exp_tx.push_back(8'hAA);
        send_word(32'h00000001, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        wait_done("done_after_reset");

        // Overflow on the four-word instance
        sel = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) expect_write(10'(i), 32'hA0000000 + 32'(i), 1'b0);
        exp_tx.push_back(8'hEE);
        send_word(32'h00000006, 1'b0);
        for (int i = 0; i < 6; i++) send_word(32'hA0000000 + 32'(i), 1'b0);
        wait_done("done_overflow");
        check("overflow_set", {31'b0, overflow_m}, 32'd1);

        // Bytes in DONE are dropped, then re-arm and reload
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        rx_valid = 1'b0;
        check("done_held_ignoring_bytes", {31'b0, done_m}, 32'd1);
        check("overflow_held_in_done", {31'b0, overflow_m}, 32'd1);
        check("rx_ready_low_in_done", {31'b0, rx_ready_m}, 32'd0);
        pulse_start();
        expect_write(10'd0, 32'h00000013, 1'b1);
        exp_tx.push_back(8'hAA);
        send_word(32'h00000001, 1'b0);
        send_word(32'h00000013, 1'b0);
        wait_done("done_rearmed");
        check("overflow_rearmed", {31'b0, overflow_m}, 32'd0);

        repeat (3) @(posedge clock);
        check("writes_outstanding", exp_wr.size(), 32'd0);
        check("tx_outstanding", exp_tx.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
